priority_arbiter: RTL and testbench

Parametrised N-channel request arbiter with a one-entry registered output stage. Each cycle it selects one valid requester, by fixed priority or round-robin according to a mode input, and transfers that requester's data word to a single valid/ready output port. It sits between several producer channels and one shared consumer. It generalises a fixed if/else-if priority chain to a configurable channel count, data width and arbitration mode.

---
 rtl/priority_arbiter.sv | 108 ++++++++++
 tb/tb_priority_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/priority_arbiter.sv
// N-channel request arbiter (fixed priority or round-robin) feeding a
// one-entry registered valid/ready output stage.
module priority_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int ID_W   = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [ID_W-1:0]         out_id,
    output logic [15:0]             grant_cnt
);

    // Channel index ptr+k, wrapped modulo N_REQ (N_REQ need not be a power of two).
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] ptr, input int k);
        int s;
        s = int'(ptr) + k;
        if (s >= N_REQ)
            s = s - N_REQ;
        return ID_W'(s);
    endfunction

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   winner;
    logic              win_found;
    logic [DATA_W-1:0] win_data;
    logic              accept;
    logic              xfer;
    logic [N_REQ-1:0]  grant;

    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;
    logic [ID_W-1:0]   id_p1;
    logic [15:0]       cnt_p1;

    always_comb begin
        winner    = '0;
        win_found = 1'b0;
        if (!mode) begin
            // Descending scan so the lowest valid index is the last one written.
            for (int i = N_REQ - 1; i >= 0; i--) begin
                if (req_valid[i]) begin
                    winner    = ID_W'(i);
                    win_found = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!win_found && req_valid[wrap_add(rr_ptr, k)]) begin
                    winner    = wrap_add(rr_ptr, k);
                    win_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == ID_W'(i))
                win_data = req_data[i*DATA_W +: DATA_W];
        end
    end

    assign accept = !vld_p1 || out_ready;
    assign xfer   = accept && win_found && !rst;

    always_comb begin
        grant = '0;
        if (xfer)
            grant[winner] = 1'b1;
    end

    assign req_ready = grant;

    // Stage p1: registered output word, counter and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            id_p1   <= '0;
            cnt_p1  <= '0;
            rr_ptr  <= '0;
        end else if (xfer) begin
            vld_p1  <= 1'b1;
            data_p1 <= win_data;
            id_p1   <= winner;
            cnt_p1  <= cnt_p1 + 16'd1;
            if (mode)
                rr_ptr <= wrap_add(winner, 1);
        end else if (vld_p1 && out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_id    = id_p1;
    assign grant_cnt = cnt_p1;

endmodule

// File: tb/tb_priority_arbiter.sv
// Directed self-checking bench for priority_arbiter (N_REQ=4, DATA_W=8).
module tb_priority_arbiter;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 8;
    localparam int ID_W   = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    mode;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       out_data;
    logic [ID_W-1:0]         out_id;
    logic [15:0]             grant_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    priority_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id), .grant_cnt(grant_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b0; req_valid = 4'b1111; out_ready = 1'b1;
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int c = 0; c < 2; c++) begin
            step();
            n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %0b want 0", out_valid); else n_pass++;
            n_chk++; if (out_data !== 8'h00) $display("FAIL rst_data: got %h want 00", out_data); else n_pass++;
            n_chk++; if (out_id !== 2'd0) $display("FAIL rst_id: got %0d want 0", out_id); else n_pass++;
            n_chk++; if (grant_cnt !== 16'd0) $display("FAIL rst_cnt: got %0d want 0", grant_cnt); else n_pass++;
            n_chk++; if (req_ready !== 4'b0000) $display("FAIL rst_ready: got %b want 0000", req_ready); else n_pass++;
        end
        rst = 1'b0;
        #1;
        n_chk++; if (req_ready !== 4'b0001) $display("FAIL post_rst_ready: got %b want 0001", req_ready); else n_pass++;
        step();
        n_chk++; if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== 8'h11)
            $display("FAIL first_grant: got v=%0b id=%0d d=%h want v=1 id=0 d=11", out_valid, out_id, out_data);
        else n_pass++;
        n_chk++; if (grant_cnt !== 16'd1) $display("FAIL first_cnt: got %0d want 1", grant_cnt); else n_pass++;
    endtask

    task automatic test_fixed_priority();
        mode = 1'b0; req_valid = 4'b1110; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_chk++; if (req_ready !== 4'b0010) $display("FAIL fixed_ready: got %b want 0010", req_ready); else n_pass++;
            step();
            n_chk++; if (out_id !== 2'd1 || out_data !== 8'h22 || out_valid !== 1'b1)
                $display("FAIL fixed_out: got v=%0b id=%0d d=%h want v=1 id=1 d=22", out_valid, out_id, out_data);
            else n_pass++;
        end
        n_chk++; if (grant_cnt !== 16'd5) $display("FAIL fixed_cnt: got %0d want 5", grant_cnt); else n_pass++;
        req_valid = 4'b0000;
        #1;
        n_chk++; if (req_ready !== 4'b0000) $display("FAIL idle_ready: got %b want 0000", req_ready); else n_pass++;
        step();
        n_chk++; if (out_valid !== 1'b0) $display("FAIL idle_drain: got %0b want 0", out_valid); else n_pass++;
        n_chk++; if (grant_cnt !== 16'd5 || out_id !== 2'd1 || out_data !== 8'h22)
            $display("FAIL idle_hold: got cnt=%0d id=%0d d=%h want cnt=5 id=1 d=22", grant_cnt, out_id, out_data);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [ID_W-1:0] exp_id [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [DATA_W-1:0] exp_d;
        do_reset();
        mode = 1'b1; req_valid = 4'b1111; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            exp_d = 8'h11 * (DATA_W'(exp_id[c]) + 8'd1);
            n_chk++; if (out_id !== exp_id[c] || out_data !== exp_d || out_valid !== 1'b1)
                $display("FAIL rr_seq%0d: got v=%0b id=%0d d=%h want v=1 id=%0d d=%h", c, out_valid, out_id, out_data, exp_id[c], exp_d);
            else n_pass++;
        end
        n_chk++; if (grant_cnt !== 16'd6) $display("FAIL rr_cnt: got %0d want 6", grant_cnt); else n_pass++;
        req_valid = 4'b0000;
        step();
    endtask

    task automatic test_backpressure();
        // rr_ptr is 2 here, so the full request set grants channel 2 first.
        mode = 1'b1; req_valid = 4'b1111; out_ready = 1'b1;
        step();
        n_chk++; if (out_id !== 2'd2 || out_data !== 8'h33) $display("FAIL bp_first: got id=%0d d=%h want id=2 d=33", out_id, out_data); else n_pass++;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_chk++; if (req_ready !== 4'b0000) $display("FAIL bp_ready%0d: got %b want 0000", c, req_ready); else n_pass++;
            step();
            n_chk++; if (out_valid !== 1'b1 || out_id !== 2'd2 || out_data !== 8'h33 || grant_cnt !== 16'd7)
                $display("FAIL bp_hold%0d: got v=%0b id=%0d d=%h cnt=%0d want v=1 id=2 d=33 cnt=7", c, out_valid, out_id, out_data, grant_cnt);
            else n_pass++;
        end
        out_ready = 1'b1;
        #1;
        n_chk++; if (req_ready !== 4'b1000) $display("FAIL bp_release_ready: got %b want 1000", req_ready); else n_pass++;
        step();
        n_chk++; if (out_id !== 2'd3 || out_data !== 8'h44 || grant_cnt !== 16'd8)
            $display("FAIL bp_release: got id=%0d d=%h cnt=%0d want id=3 d=44 cnt=8", out_id, out_data, grant_cnt);
        else n_pass++;
    endtask

    task automatic test_sparse_wrap();
        logic [ID_W-1:0] exp_id [3] = '{2'd0, 2'd2, 2'd0};
        mode = 1'b1; out_ready = 1'b1;
        req_valid = 4'b0100;
        step();
        n_chk++; if (out_id !== 2'd2) $display("FAIL sparse_setup: got id=%0d want 2", out_id); else n_pass++;
        req_valid = 4'b0101;
        for (int c = 0; c < 3; c++) begin
            step();
            n_chk++; if (out_id !== exp_id[c] || out_valid !== 1'b1)
                $display("FAIL sparse_seq%0d: got v=%0b id=%0d want v=1 id=%0d", c, out_valid, out_id, exp_id[c]);
            else n_pass++;
        end
        n_chk++; if (grant_cnt !== 16'd12) $display("FAIL sparse_cnt: got %0d want 12", grant_cnt); else n_pass++;
        req_valid = 4'b0000;
        step();
    endtask

    task automatic test_reset_mode_switch();
        do_reset();
        mode = 1'b1; req_valid = 4'b1111; out_ready = 1'b1;
        step();
        n_chk++; if (out_id !== 2'd0) $display("FAIL mid_stream0: got id=%0d want 0", out_id); else n_pass++;
        step();
        n_chk++; if (out_id !== 2'd1) $display("FAIL mid_stream1: got id=%0d want 1", out_id); else n_pass++;
        rst = 1'b1;
        #1;
        n_chk++; if (req_ready !== 4'b0000) $display("FAIL mid_rst_ready: got %b want 0000", req_ready); else n_pass++;
        step();
        n_chk++; if (out_valid !== 1'b0 || grant_cnt !== 16'd0)
            $display("FAIL mid_rst_state: got v=%0b cnt=%0d want v=0 cnt=0", out_valid, grant_cnt);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_chk++; if (req_ready !== 4'b0001) $display("FAIL mid_rst_ptr: got %b want 0001", req_ready); else n_pass++;
        step();
        n_chk++; if (out_id !== 2'd0 || out_valid !== 1'b1) $display("FAIL mid_after_rst: got v=%0b id=%0d want v=1 id=0", out_valid, out_id); else n_pass++;
        mode = 1'b0; req_valid = 4'b1000;
        step();
        n_chk++; if (out_id !== 2'd3 || out_data !== 8'h44) $display("FAIL mode0_ch3: got id=%0d d=%h want id=3 d=44", out_id, out_data); else n_pass++;
        req_valid = 4'b1010;
        step();
        n_chk++; if (out_id !== 2'd1 || out_data !== 8'h22 || out_valid !== 1'b1)
            $display("FAIL mode0_ch1: got v=%0b id=%0d d=%h want v=1 id=1 d=22", out_valid, out_id, out_data);
        else n_pass++;
        n_chk++; if (grant_cnt !== 16'd3) $display("FAIL mode0_cnt: got %0d want 3", grant_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_backpressure();
        test_sparse_wrap();
        test_reset_mode_switch();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
